// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment display between N requesters.
// A winner keeps the display for at least HOLD_CYCLES; handovers insert a single blank cycle.
module sseg_display_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter logic [31:0] BLANK_WORD  = 32'h20202020
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] words,
  output logic [N-1:0]    grant,
  output logic [2:0]      owner,
  output logic            busy,
  output logic [31:0]     word
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    SWITCH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    rr_ptr;

  logic [3:0]    idle_pick;
  logic [3:0]    sw_pick;
  logic [2:0]    next_ptr;
  logic [31:0]   owner_word;
  logic          req_owner;
  logic          any_other;
  logic          sat;

  // First set bit of r searching upward from start with wrap; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [N-1:0] r, input logic [2:0] start);
    logic [2*N-1:0] dbl;
    logic [3:0]     idx;
    logic [3:0]     res;
    dbl = {r, r} >> start;
    res = 4'b0;
    for (int k = 0; k < int'(N); k++) begin
      idx = {1'b0, start} + 4'(k);
      if (idx >= 4'(N)) idx = idx - 4'(N);
      if (!res[3] && dbl[k]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

  always_comb begin
    owner_word = BLANK_WORD;
    for (int i = 0; i < int'(N); i++) begin
      if (owner == 3'(i)) owner_word = words[32*i +: 32];
    end
  end

  always_comb begin
    next_ptr  = (owner == 3'(N - 1)) ? 3'd0 : owner + 3'd1;
    idle_pick = rr_pick(req, rr_ptr);
    // The old owner is visited last, so it only wins when nobody else is asking.
    sw_pick   = rr_pick(req, next_ptr);
    req_owner = |(req & grant);
    any_other = |(req & ~grant);
    sat       = (cnt >= HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= 3'd0;
      busy   <= 1'b0;
      word   <= BLANK_WORD;
      cnt    <= '0;
      rr_ptr <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          word <= BLANK_WORD;
          if (idle_pick[3]) begin
            state <= SHOW;
            grant <= N'(1) << idle_pick[2:0];
            owner <= idle_pick[2:0];
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        SHOW: begin
          if (sat && any_other) begin
            state <= SWITCH;
            grant <= '0;
            busy  <= 1'b0;
            word  <= BLANK_WORD;
          end else if (sat && !req_owner) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            word  <= BLANK_WORD;
          end else begin
            if (cnt != HOLD_MAX) cnt <= cnt + CW'(1);
            // A released owner still holds the display; its last word stays frozen.
            if (req_owner) word <= owner_word;
          end
        end
        SWITCH: begin
          rr_ptr <= next_ptr;
          word   <= BLANK_WORD;
          if (sw_pick[3]) begin
            state <= SHOW;
            grant <= N'(1) << sw_pick[2:0];
            owner <= sw_pick[2:0];
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          word  <= BLANK_WORD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Scoreboard bench for sseg_display_arbiter (N=4, HOLD_CYCLES=4): directed stimulus
// queues per-edge expectations, a negedge monitor pops and compares them.
module tb_sseg_display_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned HOLD = 4;
  localparam logic [31:0] BLANK = 32'h20202020;
  localparam logic [31:0] W0 = "R0-a";
  localparam logic [31:0] W1 = "R1-b";
  localparam logic [31:0] W2 = "ab12";
  localparam logic [31:0] W3 = "R3-d";
  localparam logic [31:0] W1_NEW = "NEW1";

  typedef struct packed {
    logic [3:0]  g;
    logic        b;
    logic [2:0]  o;
    logic [31:0] wd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [31:0]  w [4];
  logic [127:0] words;
  logic [3:0]   grant;
  logic [2:0]   owner;
  logic         busy;
  logic [31:0]  word;

  exp_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  assign words = {w[3], w[2], w[1], w[0]};

  always #5 clk = ~clk;

  sseg_display_arbiter #(
    .N(N),
    .HOLD_CYCLES(HOLD),
    .BLANK_WORD(BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .words(words),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .word(word)
  );

  function automatic logic [3:0] oh(input int unsigned i);
    return 4'(1) << i;
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic b, input logic [2:0] o,
                              input logic [31:0] wd);
    exp_t e;
    e.g = g;
    e.b = b;
    e.o = o;
    e.wd = wd;
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    checks++;
    if (grant !== e.g || busy !== e.b || word !== e.wd || (e.b && owner !== e.o)) begin
      errors++;
      $display("FAIL %s: got grant=%b busy=%b owner=%0d word=%h, want grant=%b busy=%b owner=%0d word=%h",
               name, grant, busy, owner, word, e.g, e.b, e.o, e.wd);
    end
  endtask

  // Expected outputs after the next rising edge.
  task automatic expect_edge(input string name, input logic [3:0] g, input logic b,
                             input logic [2:0] o, input logic [31:0] wd);
    @(posedge clk);
    #1;
    q.push_back(mk(g, b, o, wd));
    nq.push_back(name);
  endtask

  // Assert reset between edges, check the immediate clear, release with new req.
  task automatic do_reset(input logic [3:0] req_after);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("rst_clear", mk(4'b0, 1'b0, 3'd0, BLANK));
    expect_edge("in_reset", 4'b0, 1'b0, 3'd0, BLANK);
    expect_edge("in_reset", 4'b0, 1'b0, 3'd0, BLANK);
    req = req_after;
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) check_out(nq.pop_front(), q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
    $fatal(1);
  end

  initial begin
    int seq [4];
    seq = '{0, 1, 3, 0};
    w[0] = W0;
    w[1] = W1;
    w[2] = W2;
    w[3] = W3;
    rst_n = 1'b1;
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_async", mk(4'b0, 1'b0, 3'd0, BLANK));
    repeat (3) expect_edge("reset_hold", 4'b0, 1'b0, 3'd0, BLANK);
    req = 4'b0000;
    rst_n = 1'b1;

    // Single requester, releases early
    req = 4'b0100;
    expect_edge("t2_grant", 4'b0100, 1'b1, 3'd2, BLANK);
    expect_edge("t2_word", 4'b0100, 1'b1, 3'd2, W2);
    expect_edge("t2_word", 4'b0100, 1'b1, 3'd2, W2);
    req = 4'b0000;
    expect_edge("t2_hold", 4'b0100, 1'b1, 3'd2, W2);
    expect_edge("t2_release", 4'b0000, 1'b0, 3'd0, BLANK);
    expect_edge("t2_idle", 4'b0000, 1'b0, 3'd0, BLANK);

    // Simultaneous requests, round-robin with wrap
    do_reset(4'b1011);
    for (int i = 0; i < 4; i++) begin
      expect_edge("t3_grant", oh(seq[i]), 1'b1, 3'(seq[i]), BLANK);
      repeat (3) expect_edge("t3_show", oh(seq[i]), 1'b1, 3'(seq[i]), w[seq[i]]);
      if (i < 3) expect_edge("t3_gap", 4'b0000, 1'b0, 3'd0, BLANK);
    end

    // Early release: grant holds, word frozen even if the source changes
    do_reset(4'b0010);
    expect_edge("t4_grant", 4'b0010, 1'b1, 3'd1, BLANK);
    expect_edge("t4_word", 4'b0010, 1'b1, 3'd1, W1);
    req = 4'b0000;
    w[1] = W1_NEW;
    expect_edge("t4_frozen", 4'b0010, 1'b1, 3'd1, W1);
    expect_edge("t4_frozen", 4'b0010, 1'b1, 3'd1, W1);
    expect_edge("t4_idle", 4'b0000, 1'b0, 3'd0, BLANK);
    w[1] = W1;

    // Sole owner keeps the display past saturation
    req = 4'b0001;
    expect_edge("t5_grant", 4'b0001, 1'b1, 3'd0, BLANK);
    repeat (19) expect_edge("t5_hold", 4'b0001, 1'b1, 3'd0, W0);
    req = 4'b0000;
    expect_edge("t5_release", 4'b0000, 1'b0, 3'd0, BLANK);

    // Async reset mid-SHOW of owner 3
    do_reset(4'b1000);
    expect_edge("t6_grant", 4'b1000, 1'b1, 3'd3, BLANK);
    expect_edge("t6_word", 4'b1000, 1'b1, 3'd3, W3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("t6_async_clear", mk(4'b0, 1'b0, 3'd0, BLANK));
    #1;
    rst_n = 1'b1;
    expect_edge("t6_regrant", 4'b1000, 1'b1, 3'd3, BLANK);
    expect_edge("t6_word2", 4'b1000, 1'b1, 3'd3, W3);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
